wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Runs the wash programme once the billing block has charged the customer and pulses start.
- Steps through FILL, WASH, RINSE and SPIN phases with per-mode durations counted in seconds, and drives the water valves and the motor.
- Exports the phase and the seconds remaining, so the display scanner and the status LEDs can show progress.
- Supports pause and abort; issues a one-cycle done pulse when the programme completes.

Parameters:
- CYC_PER_SEC, 100_000_000, clk cycles per one-second tick; the bench overrides it to 4.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low; clock is clk
- start  input  1  one-cycle pulse from billing (its next output) requesting a programme
- mode  input  2  00 dry (spin only), 01 small, 10 medium, 11 large; sampled only when start is accepted
- pause  input  1  level; freezes the programme while high
- abort  input  1  one-cycle pulse; cancels the running programme
- busy  output  1  high in any state except IDLE
- phase  output  3  current phase code (see package)
- remain_s  output  10  total seconds left in the programme, binary
- phase_s  output  8  seconds left in the current phase, binary
- valve_in  output  1  inlet valve on
- valve_out  output  1  drain valve on
- motor  output  2  00 off, 01 slow, 10 fast
- done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (asynchronous, rst low):
  - state IDLE; busy=0, phase=IDLE, remain_s=0, phase_s=0, valve_in=0, valve_out=0, motor=00, done=0.
  - Latched mode=00; prescaler=0.
- Duration table in seconds, FILL/WASH/RINSE/SPIN; total in brackets:
  - dry 0/0/0/30 (30)
  - small 10/60/30/30 (130)
  - medium 15/90/45/40 (190)
  - large 20/120/60/60 (260)
- States: IDLE, FILL, WASH, RINSE, SPIN, DONE.
- Accepting start:
  - In IDLE, start=1 at edge N latches mode.
  - At N+1: remain_s=total, prescaler cleared, state = first phase with nonzero duration, phase_s = that phase's duration.
- Zero-duration phases are skipped in the same transition; they are never visible for a cycle.
- start while busy is ignored. The latched mode is never changed mid-programme.
- Tick:
  - The prescaler counts 0..CYC_PER_SEC-1 while in a run phase and pause=0; tick=1 on the cycle it is at the terminal count, then it wraps to 0.
  - While pause=1 the prescaler holds its value and is not cleared.
- On tick, remain_s and phase_s decrement by 1 at that edge.
- If phase_s was 1 on the tick:
  - The state advances to the next nonzero phase and phase_s loads its duration at the same edge.
  - After SPIN the state goes to DONE with phase_s=0 and remain_s=0.
- DONE lasts exactly 1 cycle: done=1, busy=1, actuators off. Next cycle IDLE, done=0.
- Actuator outputs are registered and change on the same edge as phase:
  - FILL: valve_in=1, motor=00.
  - WASH: motor=01.
  - RINSE: valve_in=1, valve_out=1, motor=01.
  - SPIN: valve_out=1, motor=10.
  - IDLE/DONE: all off.
- Pause:
  - Outputs hold their phase values, except that motor is forced to 00 while pause=1.
  - Valves hold their values.
- Abort in any run phase:
  - Next edge goes to IDLE with all outputs at reset values and no done pulse.
  - Abort in IDLE or DONE has no effect.
- Simultaneous events:
  - abort and tick in the same cycle: abort wins, no decrement.
  - start and abort in IDLE: start accepted.
  - start with pause=1: accepted; counting begins when pause falls.
- Invariant while busy and not DONE: remain_s = phase_s + sum of the durations of the remaining phases.
- Widths: remain_s is never below 0; phase_s max 120 fits in 8 bits.
- Reset mid-operation returns immediately to reset values; no state is retained.

Decomposition:
- Package wm_pkg holds:
  - phase codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5
  - motor codes
  - the mode encoding, shared with billing
  - a function returning the duration for a (mode, phase) pair, and the per-mode total
- Sub-module sec_tick: prescaler with en and clr inputs and a tick output, parameter CYC_PER_SEC. It is reusable by billing for its display timer.

Test Plan (CYC_PER_SEC=4):
- Reset, then start with mode=01 -> next cycle phase=FILL, phase_s=10, remain_s=130, valve_in=1. After 40 cycles phase=WASH, phase_s=60, remain_s=120.
- mode=00 start -> next cycle phase=SPIN directly, phase_s=30, valve_out=1, motor=10. After 120 cycles one cycle of DONE with done=1, then IDLE with busy=0.
- mode=11 full run -> done pulses exactly 1040 cycles after the start acceptance edge, and the invariant holds at every tick.
- In WASH, pause=1 for 50 cycles -> phase_s and remain_s frozen, motor=00, valves unchanged. After release, the next tick arrives after the prescaler remainder, not a full 4 cycles.
- abort issued in RINSE, and separately abort coinciding with tick -> next cycle IDLE, all outputs 0, done never asserted, remain_s=0.
- Second start while busy (mode=10 during a mode=01 run) -> ignored; the run continues with the small-load table. Start and abort together in IDLE -> programme starts.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washer definitions: phase/motor/mode encodings, actuator payload and the
// per-mode duration table used by the sequencer and billing.
package wm_pkg;

    localparam int unsigned REMAIN_W  = 10;
    localparam int unsigned PHASE_S_W = 8;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        MOTOR_OFF  = 2'b00,
        MOTOR_SLOW = 2'b01,
        MOTOR_FAST = 2'b10
    } motor_t;

    typedef enum logic [1:0] {
        MODE_DRY    = 2'b00,
        MODE_SMALL  = 2'b01,
        MODE_MEDIUM = 2'b10,
        MODE_LARGE  = 2'b11
    } mode_t;

    typedef struct packed {
        logic   valve_in;
        logic   valve_out;
        motor_t motor;
    } act_t;

    // Seconds spent in phase p for mode m; non-run phases last zero seconds.
    function automatic logic [PHASE_S_W-1:0] phase_secs(mode_t m, phase_t p);
        logic [PHASE_S_W-1:0] s;
        s = '0;
        case (p)
            PH_FILL: case (m)
                MODE_SMALL:  s = 8'd10;
                MODE_MEDIUM: s = 8'd15;
                MODE_LARGE:  s = 8'd20;
                default:     s = 8'd0;
            endcase
            PH_WASH: case (m)
                MODE_SMALL:  s = 8'd60;
                MODE_MEDIUM: s = 8'd90;
                MODE_LARGE:  s = 8'd120;
                default:     s = 8'd0;
            endcase
            PH_RINSE: case (m)
                MODE_SMALL:  s = 8'd30;
                MODE_MEDIUM: s = 8'd45;
                MODE_LARGE:  s = 8'd60;
                default:     s = 8'd0;
            endcase
            PH_SPIN: case (m)
                MODE_DRY:    s = 8'd30;
                MODE_SMALL:  s = 8'd30;
                MODE_MEDIUM: s = 8'd40;
                default:     s = 8'd60;
            endcase
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [REMAIN_W-1:0] total_secs(mode_t m);
        logic [REMAIN_W-1:0] t;
        case (m)
            MODE_DRY:    t = 10'd30;
            MODE_SMALL:  t = 10'd130;
            MODE_MEDIUM: t = 10'd190;
            default:     t = 10'd260;
        endcase
        return t;
    endfunction

    // First phase after p with a nonzero duration, or DONE when none remains.
    function automatic phase_t next_phase(mode_t m, phase_t p);
        phase_t n;
        n = PH_DONE;
        if (p == PH_IDLE && phase_secs(m, PH_FILL) != '0)
            n = PH_FILL;
        else if (p inside {PH_IDLE, PH_FILL} && phase_secs(m, PH_WASH) != '0)
            n = PH_WASH;
        else if (p inside {PH_IDLE, PH_FILL, PH_WASH} && phase_secs(m, PH_RINSE) != '0)
            n = PH_RINSE;
        else if (p inside {PH_IDLE, PH_FILL, PH_WASH, PH_RINSE} && phase_secs(m, PH_SPIN) != '0)
            n = PH_SPIN;
        return n;
    endfunction

    function automatic act_t phase_act(phase_t p, logic pause);
        act_t a;
        a = '0;
        case (p)
            PH_FILL:  a.valve_in = 1'b1;
            PH_WASH:  a.motor = MOTOR_SLOW;
            PH_RINSE: begin
                a.valve_in  = 1'b1;
                a.valve_out = 1'b1;
                a.motor     = MOTOR_SLOW;
            end
            PH_SPIN: begin
                a.valve_out = 1'b1;
                a.motor     = MOTOR_FAST;
            end
            default: a = '0;
        endcase
        if (pause)
            a.motor = MOTOR_OFF;
        return a;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts enabled cycles and flags the terminal count.
module sec_tick #(
    parameter int unsigned CYC_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;
    localparam logic [CW-1:0] TERM = CW'(CYC_PER_SEC - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    // Holds while disabled so a paused second resumes where it left off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/wash_sequencer.sv
// Wash programme sequencer: FILL/WASH/RINSE/SPIN with per-mode second timers,
// valve/motor drive, pause/abort and a one-cycle completion pulse.
module wash_sequencer
    import wm_pkg::*;
#(
    parameter int unsigned CYC_PER_SEC = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic                 pause,
    input  logic                 abort,
    output logic                 busy,
    output logic [2:0]           phase,
    output logic [REMAIN_W-1:0]  remain_s,
    output logic [PHASE_S_W-1:0] phase_s,
    output logic                 valve_in,
    output logic                 valve_out,
    output logic [1:0]           motor,
    output logic                 done
);

    phase_t state;
    mode_t  mode_q;
    act_t   act_q;
    logic   run_c;
    logic   tick;
    phase_t first_c;
    phase_t next_c;

    assign run_c   = state inside {PH_FILL, PH_WASH, PH_RINSE, PH_SPIN};
    assign first_c = next_phase(mode_t'(mode), PH_IDLE);
    assign next_c  = next_phase(mode_q, state);

    sec_tick #(.CYC_PER_SEC(CYC_PER_SEC)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run_c && !pause),
        .clr  (state == PH_IDLE),
        .tick (tick)
    );

    assign phase     = state;
    assign valve_in  = act_q.valve_in;
    assign valve_out = act_q.valve_out;
    assign motor     = act_q.motor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PH_IDLE;
            mode_q   <= MODE_DRY;
            act_q    <= '0;
            busy     <= 1'b0;
            remain_s <= '0;
            phase_s  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                PH_IDLE: begin
                    if (start) begin
                        mode_q   <= mode_t'(mode);
                        state    <= first_c;
                        busy     <= 1'b1;
                        remain_s <= total_secs(mode_t'(mode));
                        phase_s  <= phase_secs(mode_t'(mode), first_c);
                        act_q    <= phase_act(first_c, pause);
                    end
                end
                PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
                    if (abort) begin
                        state    <= PH_IDLE;
                        busy     <= 1'b0;
                        remain_s <= '0;
                        phase_s  <= '0;
                        act_q    <= '0;
                    end else if (tick && phase_s == PHASE_S_W'(1)) begin
                        // Last second of this phase: jump past any zero-length phases.
                        state    <= next_c;
                        phase_s  <= phase_secs(mode_q, next_c);
                        act_q    <= phase_act(next_c, pause);
                        remain_s <= (next_c == PH_DONE || remain_s == '0) ? '0
                                                                         : remain_s - REMAIN_W'(1);
                        done     <= (next_c == PH_DONE);
                    end else begin
                        if (tick) begin
                            phase_s  <= phase_s - PHASE_S_W'(1);
                            remain_s <= (remain_s == '0) ? '0 : remain_s - REMAIN_W'(1);
                        end
                        act_q <= phase_act(state, pause);
                    end
                end
                PH_DONE: begin
                    state    <= PH_IDLE;
                    busy     <= 1'b0;
                    remain_s <= '0;
                    phase_s  <= '0;
                    act_q    <= '0;
                end
                default: begin
                    state    <= PH_IDLE;
                    busy     <= 1'b0;
                    remain_s <= '0;
                    phase_s  <= '0;
                    act_q    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: vector table, hand sequences and random traffic,
// all checked against a cycle-count model of the programme.
module tb_wash_sequencer;

    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       pause;
    logic       abort;
    logic       busy;
    logic [2:0] phase;
    logic [9:0] remain_s;
    logic [7:0] phase_s;
    logic       valve_in;
    logic       valve_out;
    logic [1:0] motor;
    logic       done;

    int errors = 0;
    int checks = 0;

    wash_sequencer #(.CYC_PER_SEC(CPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .pause     (pause),
        .abort     (abort),
        .busy      (busy),
        .phase     (phase),
        .remain_s  (remain_s),
        .phase_s   (phase_s),
        .valve_in  (valve_in),
        .valve_out (valve_out),
        .motor     (motor),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Durations per mode for FILL, WASH, RINSE, SPIN.
    int d_fill[4]  = '{0, 10, 15, 20};
    int d_wash[4]  = '{0, 60, 90, 120};
    int d_rinse[4] = '{0, 30, 45, 60};
    int d_spin[4]  = '{30, 30, 40, 60};

    function automatic int dur(int md, int ph);
        case (ph)
            1: return d_fill[md];
            2: return d_wash[md];
            3: return d_rinse[md];
            4: return d_spin[md];
            default: return 0;
        endcase
    endfunction

    function automatic int total(int md);
        return d_fill[md] + d_wash[md] + d_rinse[md] + d_spin[md];
    endfunction

    // Model: 0 idle, 1 running, 2 done; progress is running cycles since acceptance.
    int m_state = 0;
    int m_mode  = 0;
    int m_cyc   = 0;
    bit m_pq    = 0;

    typedef struct packed {
        logic       busy;
        logic [2:0] phase;
        logic [9:0] remain;
        logic [7:0] ps;
        logic       vi;
        logic       vo;
        logic [1:0] motor;
        logic       done;
    } obs_t;

    task automatic model_edge(bit st, int md, bit pz, bit ab);
        case (m_state)
            0: if (st) begin
                m_state = 1;
                m_mode  = md;
                m_cyc   = 0;
            end
            1: if (ab) m_state = 0;
               else if (!pz) begin
                   m_cyc++;
                   if (m_cyc == CPS * total(m_mode)) m_state = 2;
               end
            default: m_state = 0;
        endcase
        m_pq = pz;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        int e, cum;
        o = '0;
        if (m_state == 2) begin
            o.busy = 1'b1;
            o.phase = 3'd5;
            o.done = 1'b1;
        end else if (m_state == 1) begin
            e = m_cyc / CPS;
            cum = 0;
            o.busy = 1'b1;
            o.remain = 10'(total(m_mode) - e);
            for (int ph = 1; ph <= 4; ph++) begin
                cum += dur(m_mode, ph);
                if (cum > e && o.phase == 3'd0) begin
                    o.phase = 3'(ph);
                    o.ps = 8'(cum - e);
                end
            end
            o.vi = (o.phase == 3'd1 || o.phase == 3'd3);
            o.vo = (o.phase == 3'd3 || o.phase == 3'd4);
            if (!m_pq)
                o.motor = (o.phase == 3'd4) ? 2'b10 :
                          (o.phase == 3'd2 || o.phase == 3'd3) ? 2'b01 : 2'b00;
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.busy = busy; o.phase = phase; o.remain = remain_s; o.ps = phase_s;
        o.vi = valve_in; o.vo = valve_out; o.motor = motor; o.done = done;
        return o;
    endfunction

    task automatic check_obs(string name, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got busy=%0b ph=%0d rem=%0d ps=%0d vi=%0b vo=%0b mot=%0d done=%0b exp busy=%0b ph=%0d rem=%0d ps=%0d vi=%0b vo=%0b mot=%0d done=%0b",
                     name, $time, got.busy, got.phase, got.remain, got.ps, got.vi, got.vo, got.motor, got.done,
                     exp.busy, exp.phase, exp.remain, exp.ps, exp.vi, exp.vo, exp.motor, exp.done);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge(start, int'(mode), pause, abort);
        #1;
        check_obs("model", dut_obs(), model_obs());
    endtask

    task automatic apply(int n, bit st, int md, bit pz, bit ab);
        for (int i = 0; i < n; i++) begin
            start = (i == 0) ? st : 1'b0;
            abort = (i == 0) ? ab : 1'b0;
            mode  = 2'(md);
            pause = pz;
            cycle();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        int n; bit st; int md; bit pz; bit ab;
        int ph; int ps; int rem; bit busy; bit done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int k;
        bit seen;
        int later;

        rst = 1'b0; start = 1'b0; mode = 2'd0; pause = 1'b0; abort = 1'b0;
        #12;
        check_obs("reset", dut_obs(), obs_t'('0));
        @(negedge clk);
        rst = 1'b1;

        vecs.push_back('{1,   1, 1, 0, 0, 1, 10, 130, 1, 0});
        vecs.push_back('{40,  0, 1, 0, 0, 2, 60, 120, 1, 0});
        vecs.push_back('{2,   0, 1, 0, 0, 2, 60, 120, 1, 0});
        vecs.push_back('{50,  0, 1, 1, 0, 2, 60, 120, 1, 0});
        vecs.push_back('{2,   0, 1, 0, 0, 2, 59, 119, 1, 0});
        vecs.push_back('{1,   0, 1, 0, 1, 0, 0,   0,   0, 0});
        vecs.push_back('{1,   1, 0, 0, 1, 4, 30,  30,  1, 0});
        vecs.push_back('{1,   1, 2, 0, 0, 4, 30,  30,  1, 0});
        vecs.push_back('{118, 0, 0, 0, 0, 4, 1,   1,   1, 0});
        vecs.push_back('{1,   0, 0, 0, 0, 5, 0,   0,   1, 1});
        vecs.push_back('{1,   0, 0, 0, 0, 0, 0,   0,   0, 0});
        vecs.push_back('{1,   1, 1, 0, 0, 1, 10, 130, 1, 0});
        vecs.push_back('{1,   1, 2, 0, 0, 1, 10, 130, 1, 0});
        vecs.push_back('{39,  0, 2, 0, 0, 2, 60, 120, 1, 0});
        vecs.push_back('{240, 0, 0, 0, 0, 3, 30,  60,  1, 0});
        vecs.push_back('{3,   0, 0, 0, 0, 3, 30,  60,  1, 0});
        vecs.push_back('{1,   0, 0, 0, 1, 0, 0,   0,   0, 0});
        vecs.push_back('{1,   1, 1, 1, 0, 1, 10, 130, 1, 0});
        vecs.push_back('{10,  0, 1, 1, 0, 1, 10, 130, 1, 0});
        vecs.push_back('{4,   0, 1, 0, 0, 1, 9,  129, 1, 0});
        vecs.push_back('{1,   0, 1, 0, 1, 0, 0,   0,   0, 0});

        foreach (vecs[i]) begin
            apply(vecs[i].n, vecs[i].st, vecs[i].md, vecs[i].pz, vecs[i].ab);
            check_int($sformatf("vec%0d_phase", i), int'(phase), vecs[i].ph);
            check_int($sformatf("vec%0d_phase_s", i), int'(phase_s), vecs[i].ps);
            check_int($sformatf("vec%0d_remain", i), int'(remain_s), vecs[i].rem);
            check_int($sformatf("vec%0d_busy_done", i), int'({busy, done}),
                      int'({vecs[i].busy, vecs[i].done}));
        end

        // Large load end to end: done after exactly 260 seconds, invariant throughout.
        apply(1, 1'b1, 3, 1'b0, 1'b0);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 1200) begin
            if (busy && phase >= 3'd1 && phase <= 3'd4) begin
                later = 0;
                for (int ph = int'(phase) + 1; ph <= 4; ph++) later += dur(3, ph);
                check_int("invariant", int'(remain_s), int'(phase_s) + later);
            end
            apply(1, 1'b0, 0, 1'b0, 1'b0);
            k++;
            if (done) seen = 1'b1;
        end
        check_int("large_done_latency", seen ? k : -1, CPS * 260);
        apply(1, 1'b0, 0, 1'b0, 1'b0);
        check_int("large_idle_after", int'({busy, done}), 0);

        // Asynchronous reset in the middle of a run.
        apply(1, 1'b1, 2, 1'b0, 1'b0);
        apply(10, 1'b0, 2, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        m_state = 0;
        m_pq = 0;
        check_obs("midrun_reset", dut_obs(), obs_t'('0));
        @(negedge clk);
        rst = 1'b1;

        // Random traffic.
        for (int i = 0; i < 8000; i++) begin
            start = ($urandom_range(15) == 0);
            abort = ($urandom_range(1499) == 0);
            mode  = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) pause = ~pause;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
